uart_tx_parity: RTL and testbench

Serial UART transmitter that frames one 8-bit byte as start, 8 data bits LSB-first, an optional parity bit and one stop bit. It is the transmit-side counterpart of the receive-path parity checker. The parity bit it generates uses the same parity_type convention: 0 = even, 1 = odd. It sits between the host byte interface and the tx pin, with one clock domain and no FIFO.

---
 rtl/uart_defs.sv | 16 +
 rtl/uart_baud_counter.sv | 19 +
 rtl/uart_tx_parity.sv | 65 ++++++
 tb/tb_uart_tx_parity.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// uart_defs: shared UART state encodings, parity conventions and data width
package uart_defs;
  localparam int DATA_BITS = 8;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;
  // parity_type 0 makes data+parity carry an even number of ones, 1 an odd number
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic parity_type);
    return (^d) ^ parity_type;
  endfunction
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts clocks within one serial bit and flags the last one
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  assign bit_tick = enable && (cnt == LAST);
endmodule

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: 8-bit UART transmitter with optional even/odd parity bit
module uart_tx_parity
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       parity_type,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_done
);
  localparam int IW = $clog2(DATA_BITS);
  state_t state, state_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IW-1:0] bit_idx;
  logic par;
  logic bit_tick;
  logic accept;
  assign accept = tx_start && tx_ready;
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state != IDLE),
    .clear    (state == IDLE),
    .bit_tick (bit_tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // byte and parity are frozen at accept so later input changes cannot reach the line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      par       <= 1'b0;
    end else if (accept) begin
      shift_reg <= tx_data;
      bit_idx   <= '0;
      par       <= parity_of(tx_data, parity_type);
    end else if (state == DATA && bit_tick) begin
      shift_reg <= shift_reg >> 1;
      bit_idx   <= bit_idx + 1'b1;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? START : IDLE;
      START:   state_nxt = bit_tick ? DATA : START;
      DATA:    state_nxt = (bit_tick && bit_idx == IW'(DATA_BITS - 1)) ? (PARITY_EN ? PARITY : STOP) : DATA;
      PARITY:  state_nxt = bit_tick ? STOP : PARITY;
      STOP:    state_nxt = bit_tick ? IDLE : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    tx_ready  = state == IDLE;
    tx_done   = state == STOP && bit_tick;
    tx_serial = state == START ? 1'b0 : state == DATA ? shift_reg[0] : state == PARITY ? par : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_parity.sv
// tb_uart_tx_parity: randomized and directed checks of uart_tx_parity against a per-cycle line model
module tb_uart_tx_parity;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic start_a, ptype_a, ready_a, serial_a, done_a;
  logic [7:0] data_a;
  logic start_b, ptype_b, ready_b, serial_b, done_b;
  logic [7:0] data_b;
  logic start_c, ptype_c, ready_c, serial_c, done_c;
  logic [7:0] data_c;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  uart_tx_parity #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_data(data_a), .parity_type(ptype_a),
    .tx_ready(ready_a), .tx_serial(serial_a), .tx_done(done_a));
  uart_tx_parity #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_data(data_b), .parity_type(ptype_b),
    .tx_ready(ready_b), .tx_serial(serial_b), .tx_done(done_b));
  uart_tx_parity #(.CLKS_PER_BIT(868), .PARITY_EN(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .tx_start(start_c), .tx_data(data_c), .parity_type(ptype_c),
    .tx_ready(ready_c), .tx_serial(serial_c), .tx_done(done_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th bit on the line: start, data LSB first, parity (if enabled), stop
  function automatic logic line_bit(input logic [7:0] d, input logic pt, input bit pe, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && pe) return ($countones(d) % 2 == 1) != pt;
    return 1'b1;
  endfunction

  logic exp_q[$];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (start_a === 1'b1)
      for (int k = 0; k < 11; k++)
        for (int r = 0; r < 4; r++) exp_q.push_back(line_bit(data_a, ptype_a, 1'b1, k));

  always @(negedge clk)
    if (chk_en) begin
      if (exp_q.size() != 0) begin
        chk("serial", serial_a, exp_q[0]);
        chk("ready", ready_a, 1'b0);
        chk("done", done_a, exp_q.size() == 1);
      end else begin
        chk("idle_serial", serial_a, 1'b1);
        chk("idle_ready", ready_a, 1'b1);
        chk("idle_done", done_a, 1'b0);
      end
    end

  task automatic wait_ready_a();
    @(posedge clk); #2;
    for (int i = 0; i < 200 && ready_a !== 1'b1; i++) begin @(posedge clk); #2; end
    chk("ready_a_wait", ready_a, 1'b1);
  endtask

  task automatic run_a(input logic [7:0] d, input logic pt, output logic [10:0] cap, output int done_cyc);
    wait_ready_a();
    start_a = 1'b1; data_a = d; ptype_a = pt;
    @(posedge clk); #2;
    start_a = 1'b0; data_a = ~d; ptype_a = ~pt;
    cap = '1;
    done_cyc = -1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (c % 4 == 2 && c < 44) cap[c/4] = serial_a;
      if (done_a === 1'b1 && done_cyc < 0) done_cyc = c;
    end
  endtask

  logic [10:0] cap;
  int done_cyc, gaps, nacc, c3, ndone;

  initial begin
    rst_n = 1'b0;
    {start_a, start_b, start_c} = '0;
    {data_a, data_b, data_c} = '0;
    {ptype_a, ptype_b, ptype_c} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", serial_a, 1'b1);
    chk("rst_ready", ready_a, 1'b1);
    chk("rst_done", done_a, 1'b0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    for (int k = 0; k < 11; k++) cap[k] = line_bit(8'hA5, 1'b0, 1'b1, k);
    chk("model_A5", cap, 11'b10101001010);
    chk("model_par07", line_bit(8'h07, 1'b1, 1'b1, 9), 1'b0);
    chk("model_par03", line_bit(8'h03, 1'b1, 1'b1, 9), 1'b1);

    run_a(8'hA5, 1'b0, cap, done_cyc);
    chk("A5_line", cap, 11'b10101001010);
    chk("A5_done_cycle", done_cyc, 43);
    run_a(8'h07, 1'b1, cap, done_cyc);
    chk("p07_bit", cap[9], 1'b0);
    chk("p07_rx_ok", ($countones(cap[9:1]) % 2) == 1, 1'b1);
    run_a(8'h03, 1'b1, cap, done_cyc);
    chk("p03_bit", cap[9], 1'b1);
    chk("p03_rx_ok", ($countones(cap[9:1]) % 2) == 1, 1'b1);

    // three frames back to back with start held, then a stray request mid-frame
    wait_ready_a();
    start_a = 1'b1; data_a = 8'h55; ptype_a = 1'b0;
    gaps = 0; nacc = 0; c3 = 0; ndone = 0;
    for (int c = 0; c < 180; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) ndone++;
      if (nacc == 3) begin
        c3++;
        if (c3 == 1) start_a = 1'b0;
        if (c3 == 10) begin start_a = 1'b1; data_a = 8'h00; end
        if (c3 == 11) begin start_a = 1'b0; data_a = 8'h55; end
      end else if (ready_a === 1'b1) begin
        if (nacc > 0) gaps++;
        nacc++;
      end
    end
    chk("b2b_frames", nacc, 3);
    chk("b2b_gaps", gaps, 2);
    chk("b2b_dones", ndone, 3);

    // reset in the middle of a frame while the line is low
    wait_ready_a();
    start_a = 1'b1; data_a = 8'h00;
    @(posedge clk); #2 start_a = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    chk("pre_reset_low", serial_a, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_serial", serial_a, 1'b1);
    chk("async_ready", ready_a, 1'b1);
    chk("async_done", done_a, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin @(negedge clk); if (done_a === 1'b1) ndone++; end
    chk("no_done_after_reset", ndone, 0);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start_a = $urandom_range(0, 3) == 0;
      data_a = 8'($urandom);
      ptype_a = 1'($urandom);
    end
    start_a = 1'b0;

    // 8N1 instance
    @(posedge clk); #2;
    start_b = 1'b1; data_b = 8'hFF; ptype_b = 1'b1;
    @(posedge clk); #2;
    start_b = 1'b0; data_b = 8'h00;
    cap = '0; done_cyc = -1;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (c % 4 == 2 && c < 40) cap[c/4] = serial_b;
      if (done_b === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c == 39) chk("n8_ready_busy", ready_b, 1'b0);
      if (c == 40) begin chk("n8_ready_back", ready_b, 1'b1); chk("n8_idle_high", serial_b, 1'b1); end
    end
    chk("n8_line", cap[9:0], 10'b1111111110);
    chk("n8_done_cycle", done_cyc, 39);

    // full-rate instance: every cycle of the frame checked against the bit schedule
    @(posedge clk); #2;
    start_c = 1'b1; data_c = 8'h5A; ptype_c = 1'b0;
    @(posedge clk); #2;
    start_c = 1'b0; data_c = 8'hFF; ptype_c = 1'b1;
    ndone = 0;
    for (int c = 0; c < 9552; c++) begin
      @(negedge clk);
      if (done_c === 1'b1) ndone++;
      if (c < 9548) begin
        chk("c_serial", serial_c, line_bit(8'h5A, 1'b0, 1'b1, c / 868));
        chk("c_done", done_c, c == 9547);
        chk("c_ready", ready_c, 1'b0);
      end else begin
        chk("c_idle_ready", ready_c, 1'b1);
        chk("c_idle_serial", serial_c, 1'b1);
      end
    end
    chk("c_done_count", ndone, 1);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
